// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter and receiver blocks:
// frame states, idle line level and frame/parity helpers.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Clock cycles from accept edge to the return-to-idle edge.
    function automatic int frame_len(input int data_w, input int parity_en, input int clks_per_bit);
        return (2 + data_w + parity_en) * clks_per_bit;
    endfunction

    // Callers zero-extend the data word into the 8-bit argument.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/serial_tx4_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each serial bit with bit_tick_o. Shared with the receiver.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk1,
    input  logic reset3,
    input  logic clear_i,
    input  logic enable_i,
    output logic bit_tick_o
);
    import serial_pkg::*;

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap on the last cycle of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk1 or posedge reset3) begin
        if (reset3) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With CLKS_PER_BIT=1 the count stays at zero and every enabled cycle ticks.
    assign bit_tick_o = enable_i & ~clear_i & (cnt_q == LAST_CNT);

endmodule

// File: rtl/serial_tx4.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits LSB
// first, optional parity bit, stop bit; every output is a flop.
module serial_tx4 #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk1,
    input  logic              reset3,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              frame_done
);
    import serial_pkg::*;

    localparam int BCNT_W = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

    tx_state_t         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BCNT_W-1:0] bit_cnt_q;
    logic              parity_q;
    logic [7:0]        data_ext_s;
    logic              accept_s;
    logic              bit_tick_s;

    // Zero-extended copy of the input word for the parity helper.
    always_comb begin
        data_ext_s = 8'd0;
        data_ext_s[DATA_W-1:0] = tx_data;
    end

    // Handshake and shift-right value (the MSB fills with zero).
    always_comb begin
        accept_s = tx_valid & tx_ready;
        shift_d  = shift_q >> 1;
    end

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk1      (clk1),
        .reset3    (reset3),
        .clear_i   (accept_s),
        .enable_i  (state_q != IDLE),
        .bit_tick_o(bit_tick_s)
    );

    // Frame FSM; the line level for the next bit is registered on the bit
    // boundary so tx_serial never depends on combinational state decode.
    always_ff @(posedge clk1 or posedge reset3) begin
        if (reset3) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            parity_q   <= 1'b0;
            tx_serial  <= LINE_IDLE;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        shift_q   <= tx_data;
                        parity_q  <= parity_bit(data_ext_s, 1'(PARITY_ODD));
                        bit_cnt_q <= '0;
                        tx_serial <= 1'b0;
                        tx_ready  <= 1'b0;
                        tx_busy   <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_tick_s) begin
                        tx_serial <= shift_q[0];
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick_s) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx_serial <= parity_q;
                                state_q   <= PARITY;
                            end else begin
                                tx_serial <= LINE_IDLE;
                                state_q   <= STOP;
                            end
                        end else begin
                            tx_serial <= shift_d[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick_s) begin
                        tx_serial <= LINE_IDLE;
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick_s) begin
                        tx_serial  <= LINE_IDLE;
                        tx_ready   <= 1'b1;
                        tx_busy    <= 1'b0;
                        frame_done <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    tx_serial <= LINE_IDLE;
                    tx_ready  <= 1'b1;
                    tx_busy   <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx4.sv
// Scoreboard bench for serial_tx4: default build (A) and a
// CLKS_PER_BIT=1, no-parity build (B) driven from directed vectors.
module tb_serial_tx4;
    import serial_pkg::*;

    typedef struct {
        logic [15:0] bits;
        int          nslots;
        int          cpb;
        int          gap;
    } exp_t;

    logic       clk1 = 1'b0;
    logic       reset3 = 1'b1;
    logic [3:0] tx_data_a = 4'd0, tx_data_b = 4'd0;
    logic       tx_valid_a = 1'b0, tx_valid_b = 1'b0;
    logic       rdy_a, ser_a, busy_a, fd_a;
    logic       rdy_b, ser_b, busy_b, fd_b;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    exp_t   q0[$];
    exp_t   q1[$];
    exp_t   cur[2];
    int     phase[2];
    int     idx[2];
    longint last_start[2];

    serial_tx4 dut_a (
        .clk1(clk1), .reset3(reset3), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(rdy_a), .tx_serial(ser_a), .tx_busy(busy_a), .frame_done(fd_a)
    );

    serial_tx4 #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_b (
        .clk1(clk1), .reset3(reset3), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(rdy_b), .tx_serial(ser_b), .tx_busy(busy_b), .frame_done(fd_b)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic [15:0] bits, input int nslots,
                            input int cpb, input int gap);
        exp_t e;
        e.bits = bits; e.nslots = nslots; e.cpb = cpb; e.gap = gap;
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // One negedge sample of one transmitter against the scoreboard.
    task automatic mon_step(input int id, input logic ser, input logic fd,
                            input logic rdy, input logic busy);
        exp_t e;
        if (reset3) begin
            phase[id] = 0;
            chk("reset_line", {31'd0, ser}, 32'd1);
            chk("reset_done", {31'd0, fd}, 32'd0);
        end else if (phase[id] == 2) begin
            chk("done_pulse", {31'd0, fd}, 32'd1);
            chk("done_line", {31'd0, ser}, 32'd1);
            chk("done_ready", {31'd0, rdy}, 32'd1);
            chk("done_busy", {31'd0, busy}, 32'd0);
            phase[id] = 0;
        end else begin
            if (phase[id] == 0) begin
                if (ser == 1'b0) begin
                    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = (id == 0) ? q0.pop_front() : q1.pop_front();
                        if (e.gap >= 0) chk("accept_gap", 32'(cyc - last_start[id]), 32'(e.gap));
                        last_start[id] = cyc;
                        cur[id] = e;
                        idx[id] = 0;
                        phase[id] = 1;
                    end
                end else begin
                    chk("idle_done", {31'd0, fd}, 32'd0);
                    chk("idle_ready", {31'd0, rdy}, 32'd1);
                    chk("idle_busy", {31'd0, busy}, 32'd0);
                end
            end
            if (phase[id] == 1) begin
                chk("frame_line", {31'd0, ser}, {31'd0, cur[id].bits[idx[id] / cur[id].cpb]});
                chk("frame_done_low", {31'd0, fd}, 32'd0);
                chk("frame_busy", {31'd0, busy}, 32'd1);
                chk("frame_ready", {31'd0, rdy}, 32'd0);
                idx[id]++;
                if (idx[id] == cur[id].nslots * cur[id].cpb) phase[id] = 2;
            end
        end
    endtask

    always @(negedge clk1) begin
        mon_step(0, ser_a, fd_a, rdy_a, busy_a);
        mon_step(1, ser_b, fd_b, rdy_b, busy_b);
    end

    // Present a word and return #1 after the accepting edge; hold keeps valid high.
    task automatic send(input int id, input logic [3:0] d, input logic hold);
        int waited = 0;
        if (id == 0) begin tx_data_a = d; tx_valid_a = 1'b1; end
        else begin tx_data_b = d; tx_valid_b = 1'b1; end
        while (((id == 0) ? rdy_a : rdy_b) !== 1'b1 && waited < 200) begin
            @(negedge clk1);
            waited++;
        end
        if (waited >= 200) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            @(posedge clk1);
        end
        #1;
        if (!hold) begin
            if (id == 0) tx_valid_a = 1'b0;
            else tx_valid_b = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || phase[0] != 0 || phase[1] != 0) && n < budget) begin
            @(negedge clk1);
            n++;
        end
        if (n >= budget) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        phase[0] = 0; phase[1] = 0;
        idx[0] = 0; idx[1] = 0;
        last_start[0] = 0; last_start[1] = 0;

        #22 reset3 = 1'b0;
        repeat (50) begin
            @(negedge clk1);
            chk("rst_line", {31'd0, ser_a}, 32'd1);
            chk("rst_ready", {31'd0, rdy_a}, 32'd1);
            chk("rst_busy", {31'd0, busy_a}, 32'd0);
        end

        // 4'b1010: 0 | 0,1,0,1 | 0 | 1  (slot 0 in bit 0)
        push_exp(0, 16'b1010100, 7, 4, -1);
        send(0, 4'b1010, 1'b0);
        wait_idle(4 * frame_len(4, 1, 4));

        // 4'b0111 then 4'b1000 with valid held: 0|1,1,1,0|1|1 then 0|0,0,0,1|1|1
        push_exp(0, 16'b1101110, 7, 4, -1);
        push_exp(0, 16'b1110000, 7, 4, 29);
        send(0, 4'b0111, 1'b1);
        send(0, 4'b1000, 1'b0);
        wait_idle(4 * frame_len(4, 1, 4));

        // 4'b0101 with tx_data/tx_valid disturbed mid-frame: 0|1,0,1,0|0|1
        push_exp(0, 16'b1001010, 7, 4, -1);
        send(0, 4'b0101, 1'b0);
        repeat (6) @(posedge clk1);
        #1 tx_data_a = 4'b1111; tx_valid_a = 1'b1;
        repeat (3) @(posedge clk1);
        #1 tx_data_a = 4'b0000;
        repeat (2) @(posedge clk1);
        #1 tx_valid_a = 1'b0;
        wait_idle(4 * frame_len(4, 1, 4));
        repeat (10) @(negedge clk1);
        chk("no_extra_frame", 32'(q0.size()), 32'd0);

        // 4'b1011 aborted by reset3 during data bit 2 (line low there)
        push_exp(0, 16'b1110110, 7, 4, -1);
        send(0, 4'b1011, 1'b0);
        repeat (12) @(posedge clk1);
        #2 chk("pre_reset_line", {31'd0, ser_a}, 32'd0);
        reset3 = 1'b1;
        #1;
        chk("async_reset_line", {31'd0, ser_a}, 32'd1);
        chk("async_reset_ready", {31'd0, rdy_a}, 32'd1);
        chk("async_reset_busy", {31'd0, busy_a}, 32'd0);
        chk("async_reset_done", {31'd0, fd_a}, 32'd0);
        repeat (2) @(negedge clk1);
        #2 reset3 = 1'b0;
        repeat (5) @(negedge clk1);

        // 4'b0001 after reset: 0|1,0,0,0|1|1
        push_exp(0, 16'b1100010, 7, 4, -1);
        send(0, 4'b0001, 1'b0);
        wait_idle(4 * frame_len(4, 1, 4));

        // CLKS_PER_BIT=1, no parity, 4'b1100: 0,0,0,1,1,1
        push_exp(1, 16'b111000, 6, 1, -1);
        send(1, 4'b1100, 1'b0);
        wait_idle(4 * frame_len(4, 0, 1));

        repeat (5) @(negedge clk1);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
